bram_scan_reader: RTL

//   Synthesizable, parametrised replacement for hand-stepped BRAM address sweeps.
//   On start, reads a BRAM address range (base..last, wrapping at DEPTH-1) and

---
 rtl/bram_scan_reader.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/bram_scan_reader.sv
// bram_scan_reader: sweeps a BRAM address range (base..last, wrapping at
// DEPTH-1) and streams each word with its address over valid/ready.
// Read latency is hidden by a credit-limited skid buffer. The buffer is the
// output register plus a small FIFO. An XOR checksum is produced per pass,
// and the sweep can optionally loop until stopped.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, loop_mode, stop    control (start/stop are 1-cycle pulses)
//   base_addr, last_addr      inclusive range, sampled on start
//   bram_en, bram_addr        BRAM read request
//   bram_dout                 BRAM read data, READ_LATENCY cycles after request
//   m_data, m_addr, m_last    stream payload
//   m_valid, m_ready          stream handshake
//   busy, done                scan status, done is a 1-cycle pulse
//   checksum, checksum_valid  XOR of the completed pass, with a 1-cycle strobe
module bram_scan_reader #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned DEPTH        = 32768,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              loop_mode,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic              checksum_valid
);

  localparam int unsigned FIFO_D = READ_LATENCY + 2;
  localparam int unsigned PIPE_D = READ_LATENCY + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_D);
  localparam int unsigned CNT_W  = $clog2(FIFO_D + 1);
  localparam int unsigned OCC_W  = $clog2(PIPE_D + FIFO_D + 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q, last_q, cur_addr;
  logic              loop_q, stop_q;
  logic [DATA_W-1:0] acc;

  // Request tracking: one stage per cycle from issue until the data is valid.
  logic [PIPE_D-1:0] pipe_v, pipe_last;
  logic [ADDR_W-1:0] pipe_addr [PIPE_D];

  logic [DATA_W-1:0] fifo_data [FIFO_D];
  logic [ADDR_W-1:0] fifo_addr [FIFO_D];
  logic [FIFO_D-1:0] fifo_last;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;

  logic              pop_c, cap_c, load_c, fifo_pop_c, fifo_push_c, direct_c;
  logic              issue_c, addr_is_last_c;
  logic [ADDR_W-1:0] issue_addr_c, next_addr_c;
  logic [OCC_W-1:0]  occ_c;

  // Handshake and buffer movement for this cycle.
  always_comb begin
    pop_c       = m_valid & m_ready;
    cap_c       = pipe_v[PIPE_D-1];
    load_c      = ~m_valid | pop_c;
    fifo_pop_c  = load_c & (fifo_cnt != '0);
    direct_c    = load_c & (fifo_cnt == '0) & cap_c;
    fifo_push_c = cap_c & ~direct_c;
  end

  // Credits: requests in flight plus buffered words. A word taken by the
  // consumer this cycle frees its slot at once, which sustains 1 word/clk.
  always_comb begin
    occ_c = '0;
    for (int i = 0; i < int'(PIPE_D); i++) begin
      occ_c = occ_c + OCC_W'(pipe_v[i]);
    end
    occ_c = occ_c + OCC_W'(fifo_cnt) + OCC_W'(m_valid) - OCC_W'(pop_c);
  end

  // Issue decision. The first read goes out on the start cycle itself.
  always_comb begin
    issue_addr_c   = (state == S_IDLE) ? base_addr : cur_addr;
    addr_is_last_c = issue_addr_c == ((state == S_IDLE) ? last_addr : last_q);
    issue_c        = ((state == S_IDLE) & start) |
                     ((state == S_ISSUE) & (occ_c < OCC_W'(FIFO_D)));
    next_addr_c    = (issue_addr_c == ADDR_W'(DEPTH - 1)) ? '0
                                                          : issue_addr_c + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      base_q         <= '0;
      last_q         <= '0;
      cur_addr       <= '0;
      loop_q         <= 1'b0;
      stop_q         <= 1'b0;
      acc            <= '0;
      pipe_v         <= '0;
      pipe_last      <= '0;
      fifo_last      <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_cnt       <= '0;
      bram_en        <= 1'b0;
      bram_addr      <= '0;
      m_data         <= '0;
      m_addr         <= '0;
      m_valid        <= 1'b0;
      m_last         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      checksum       <= '0;
      checksum_valid <= 1'b0;
      for (int i = 0; i < int'(PIPE_D); i++) pipe_addr[i] <= '0;
      for (int i = 0; i < int'(FIFO_D); i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
    end else begin
      done           <= 1'b0;
      checksum_valid <= 1'b0;

      // Read request and its tracking pipeline.
      bram_en      <= issue_c;
      pipe_v       <= {pipe_v[PIPE_D-2:0], issue_c};
      pipe_last    <= {pipe_last[PIPE_D-2:0], addr_is_last_c};
      pipe_addr[0] <= issue_addr_c;
      for (int i = 1; i < int'(PIPE_D); i++) pipe_addr[i] <= pipe_addr[i-1];
      if (issue_c) begin
        bram_addr <= issue_addr_c;
        cur_addr  <= next_addr_c;
      end

      // Returning data goes straight to the output register when it is free
      // and nothing older is queued; otherwise it waits in the FIFO.
      if (fifo_push_c) begin
        fifo_data[wr_ptr] <= bram_dout;
        fifo_addr[wr_ptr] <= pipe_addr[PIPE_D-1];
        fifo_last[wr_ptr] <= pipe_last[PIPE_D-1];
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_D - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (fifo_pop_c) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_D - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({fifo_push_c, fifo_pop_c})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: ;
      endcase

      if (load_c) begin
        if (fifo_pop_c) begin
          m_data  <= fifo_data[rd_ptr];
          m_addr  <= fifo_addr[rd_ptr];
          m_last  <= fifo_last[rd_ptr];
          m_valid <= 1'b1;
        end else if (direct_c) begin
          m_data  <= bram_dout;
          m_addr  <= pipe_addr[PIPE_D-1];
          m_last  <= pipe_last[PIPE_D-1];
          m_valid <= 1'b1;
        end else begin
          m_valid <= 1'b0;
        end
      end

      // Per-pass checksum.
      if (pop_c) begin
        if (m_last) begin
          checksum       <= acc ^ m_data;
          checksum_valid <= 1'b1;
          acc            <= '0;
        end else begin
          acc <= acc ^ m_data;
        end
      end

      case (state)
        S_IDLE: begin
          // A stop arriving together with start limits the scan to one pass.
          stop_q <= start & stop;
          if (start) begin
            base_q <= base_addr;
            last_q <= last_addr;
            loop_q <= loop_mode;
            busy   <= 1'b1;
            state  <= addr_is_last_c ? S_DRAIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          stop_q <= stop_q | stop;
          if (issue_c && addr_is_last_c) state <= S_DRAIN;
        end
        S_DRAIN: begin
          stop_q <= stop_q | stop;
          if (pop_c && m_last) begin
            if (loop_q && !(stop_q || stop)) begin
              cur_addr <= base_q;
              state    <= S_ISSUE;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          stop_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
